alu_issue_stage: RTL and testbench

- Driving end of the 32-bit ALU interface: decodes MIPS opcode/funct into the one-hot 5-bit ALU op, selects and registers operands A/B, then captures the ALU's out/zero one stage later.
- Two-entry pipeline (EX issue register, EX/MEM capture register) with valid/ready handshakes on both sides.
- Sits between ID and MEM in the pipelined datapath.
- The ALU itself stays external and combinational.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_op_decoder.sv | 67 ++++++
 rtl/alu_issue_stage.sv | 182 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ALU issue stage:
//   - one-hot ALU op encodings driven to the external ALU
//   - MIPS opcode / funct values recognised by the decoder
//   - operand-B select and branch-kind enumerations
// Optional feature macro used by the stage: ALU_ISSUE_OVF_EN (see alu_issue_stage).
// -----------------------------------------------------------------------------
package alu_pkg;

   // One-hot ALU operation codes; 5'b00000 means "no operation" (bubble/illegal)
   localparam logic [4:0] ALU_NOP = 5'b00000;
   localparam logic [4:0] ALU_ADD = 5'b00001;
   localparam logic [4:0] ALU_SUB = 5'b00010;
   localparam logic [4:0] ALU_AND = 5'b00100;
   localparam logic [4:0] ALU_SLT = 5'b01000;
   localparam logic [4:0] ALU_OR  = 5'b10000;

   // Primary opcodes, instruction[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   // R-type function codes, instruction[5:0]
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      B_REG  = 2'd0,   // rt_val
      B_SEXT = 2'd1,   // sign-extended imm16
      B_ZEXT = 2'd2    // zero-extended imm16
   } bsel_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_EQ   = 2'd1,
      BR_NE   = 2'd2
   } brkind_e;

endpackage

// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Combinational MIPS opcode/funct decoder for the ALU issue stage.
// Ports:
//   opcode  [5:0]  in   instruction[31:26]
//   funct   [5:0]  in   instruction[5:0] (only meaningful for R-type)
//   alu_op  [4:0]  out  one-hot ALU op, 0 for undecodable instructions
//   bsel           out  operand-B source select
//   brkind         out  branch kind (none / beq / bne)
//   illegal        out  instruction not recognised
// -----------------------------------------------------------------------------
module alu_op_decoder
   import alu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [4:0] alu_op,
   output bsel_e      bsel,
   output brkind_e    brkind,
   output logic       illegal
);

   always_comb begin
      alu_op  = ALU_NOP;
      bsel    = B_REG;
      brkind  = BR_NONE;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_LW, OP_SW, OP_ADDI: begin
            alu_op = ALU_ADD;
            bsel   = B_SEXT;
         end
         OP_BEQ: begin
            alu_op = ALU_SUB;
            brkind = BR_EQ;
         end
         OP_BNE: begin
            alu_op = ALU_SUB;
            brkind = BR_NE;
         end
         OP_SLTI: begin
            alu_op = ALU_SLT;
            bsel   = B_SEXT;
         end
         OP_ANDI: begin
            alu_op = ALU_AND;
            bsel   = B_ZEXT;
         end
         OP_ORI: begin
            alu_op = ALU_OR;
            bsel   = B_ZEXT;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Driving end of an external combinational 32-bit ALU. Decodes the instruction,
// registers op/operands into the EX entry (driven straight to the ALU), then
// captures the ALU result into the M entry one stage later.
// Optional feature: define ALU_ISSUE_OVF_EN to compute signed overflow for
// addi / R-add / R-sub; otherwise overflow is tied 0.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             ID-side handshake
//   opcode, funct, rs_val, rt_val, imm16, tag_in   instruction fields
//   flush                         kill the EX entry
//   alu_op, alu_a, alu_b          registered drive to the ALU
//   alu_out, alu_zero             ALU result and equality flag
//   out_valid/out_ready           MEM-side handshake
//   result, br_taken, tag_out, illegal, overflow   M entry contents
// -----------------------------------------------------------------------------
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic [15:0]       imm16,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic              flush,
   output logic [4:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              br_taken,
   output logic [TAG_W-1:0]  tag_out,
   output logic              illegal,
   output logic              overflow
);

   // Decode
   logic [4:0] dec_op;
   bsel_e      dec_bsel;
   brkind_e    dec_brkind;
   logic       dec_illegal;

   alu_op_decoder u_dec (
      .opcode  (opcode),
      .funct   (funct),
      .alu_op  (dec_op),
      .bsel    (dec_bsel),
      .brkind  (dec_brkind),
      .illegal (dec_illegal)
   );

   logic [DATA_W-1:0] b_sel;
   always_comb begin
      case (dec_bsel)
         B_SEXT:  b_sel = {{(DATA_W-16){imm16[15]}}, imm16};
         B_ZEXT:  b_sel = {{(DATA_W-16){1'b0}}, imm16};
         default: b_sel = rt_val;
      endcase
   end

   // EX entry
   logic              e_valid_q, e_valid_d;
   logic [4:0]        alu_op_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q;
   logic [TAG_W-1:0]  e_tag_q;
   brkind_e           e_brkind_q;
   logic              e_illegal_q;

   // M entry
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] result_q;
   logic              br_taken_q;
   logic [TAG_W-1:0]  tag_out_q;
   logic              illegal_q;

   logic e_adv, accept, m_load, br_now;

   always_comb begin
      e_adv    = !out_valid_q || out_ready;
      // A flush in the same cycle refuses the incoming instruction
      in_ready = !flush && (!e_valid_q || e_adv);
      accept   = in_valid && in_ready;
      // A flushed EX entry never reaches M
      m_load   = e_valid_q && e_adv && !flush;
      br_now   = ((e_brkind_q == BR_EQ) && alu_zero) ||
                 ((e_brkind_q == BR_NE) && !alu_zero);
      e_valid_d   = accept ? 1'b1 : (e_valid_q && !flush && !e_adv);
      out_valid_d = m_load ? 1'b1 : (out_valid_q && !out_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_valid_q   <= 1'b0;
         alu_op_q    <= ALU_NOP;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         e_tag_q     <= '0;
         e_brkind_q  <= BR_NONE;
         e_illegal_q <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         br_taken_q  <= 1'b0;
         tag_out_q   <= '0;
         illegal_q   <= 1'b0;
      end else begin
         e_valid_q <= e_valid_d;
         if (accept) begin
            alu_op_q    <= dec_op;
            alu_a_q     <= rs_val;
            alu_b_q     <= b_sel;
            e_tag_q     <= tag_in;
            e_brkind_q  <= dec_brkind;
            e_illegal_q <= dec_illegal;
         end else if (!e_valid_d) begin
            // Bubble: op goes to NOP, operands keep their last values
            alu_op_q <= ALU_NOP;
         end
         out_valid_q <= out_valid_d;
         if (m_load) begin
            result_q   <= alu_out;
            br_taken_q <= br_now;
            tag_out_q  <= e_tag_q;
            illegal_q  <= e_illegal_q;
         end
      end
   end

`ifdef ALU_ISSUE_OVF_EN
   // Only addi and R-add/R-sub are overflow-checked; lw/sw/beq/bne share the
   // add/sub ops but must never flag.
   logic e_ovf_chk_q, overflow_q, ovf_now;
   logic sa, sb, so;

   always_comb begin
      sa = alu_a_q[DATA_W-1];
      sb = alu_b_q[DATA_W-1];
      so = alu_out[DATA_W-1];
      ovf_now = e_ovf_chk_q &&
                (((alu_op_q == ALU_ADD) && (sa == sb) && (so != sa)) ||
                 ((alu_op_q == ALU_SUB) && (sa != sb) && (so != sa)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_ovf_chk_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (accept)
            e_ovf_chk_q <= (opcode == OP_ADDI) ||
                           ((opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)));
         if (m_load)
            overflow_q <= ovf_now;
      end
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign br_taken  = br_taken_q;
   assign tag_out   = tag_out_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Table-driven bench for alu_issue_stage with a behavioural ALU model and a
// result scoreboard, plus hand-written backpressure / flush / reset sequences.
// Honours ALU_ISSUE_OVF_EN for the expected overflow values.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [5:0]  opcode, funct;
   logic [31:0] rs_val, rt_val;
   logic [15:0] imm16;
   logic [4:0]  tag_in;
   logic        flush;
   logic [4:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        alu_zero;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic        br_taken;
   logic [4:0]  tag_out;
   logic        illegal, overflow;

   always #5 clk = ~clk;

   alu_issue_stage #(.TAG_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct(funct),
      .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .tag_in(tag_in),
      .flush(flush),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .br_taken(br_taken), .tag_out(tag_out),
      .illegal(illegal), .overflow(overflow)
   );

   // External ALU model
   always_comb begin
      case (alu_op)
         5'b00001: alu_out = alu_a + alu_b;
         5'b00010: alu_out = alu_a - alu_b;
         5'b00100: alu_out = alu_a & alu_b;
         5'b01000: alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
         5'b10000: alu_out = alu_a | alu_b;
         default:  alu_out = 32'd0;
      endcase
   end
   assign alu_zero = (alu_out == 32'd0);

   typedef struct {
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic [4:0]  e_op;
      logic [31:0] e_b;
      logic        chk_b;
      logic [31:0] e_res;
      logic        e_br;
      logic        e_ill;
      logic        e_ovf;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        br;
      logic [4:0]  tag;
      logic        ill;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];
   vec_t vt[20];
   int   errors = 0;
   int   checks = 0;
   int   n_out  = 0;

   function automatic vec_t mk(input logic [5:0] opc, input logic [5:0] fn,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [15:0] imm, input logic [4:0] op,
                               input logic [31:0] b, input logic chkb,
                               input logic [31:0] res, input logic br,
                               input logic ill, input logic ovf);
      vec_t v;
      v.opc = opc; v.fn = fn; v.rs = rs; v.rt = rt; v.imm = imm;
      v.e_op = op; v.e_b = b; v.chk_b = chkb; v.e_res = res;
      v.e_br = br; v.e_ill = ill; v.e_ovf = ovf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: one line per transfer out of the M entry
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got tag %0d result %h expected no output", tag_out, result);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("out tag=%0d result=%h br=%0d ill=%0d ovf=%0d", tag_out, result, br_taken, illegal, overflow);
            check("tag_out",  {27'd0, tag_out}, {27'd0, e.tag});
            check("result",   result, e.res);
            check("br_taken", {31'd0, br_taken}, {31'd0, e.br});
            check("illegal",  {31'd0, illegal}, {31'd0, e.ill});
            check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            n_out++;
         end
      end
   end

   task automatic drive(input vec_t v, input logic [4:0] tag);
      opcode = v.opc; funct = v.fn; rs_val = v.rs; rt_val = v.rt;
      imm16 = v.imm; tag_in = tag; in_valid = 1'b1;
   endtask

   function automatic exp_t mk_exp(input vec_t v, input logic [4:0] tag);
      exp_t e;
      e.res = v.e_res; e.br = v.e_br; e.tag = tag; e.ill = v.e_ill;
      e.ovf = v.e_ovf && OVF_EN;
      return e;
   endfunction

   // Present one instruction and wait (bounded) for it to be accepted
   task automatic issue(input vec_t v, input logic [4:0] tag);
      bit done;
      done = 1'b0;
      drive(v, tag);
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back(mk_exp(v, tag));
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got in_ready=0 for 20 cycles expected acceptance (tag %0d)", tag);
      end
      $display("issue tag=%0d opcode=%b funct=%b", tag, v.opc, v.fn);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
      #1;
      check(name, sb_q.size(), 32'd0);
   endtask

   initial begin
      // opc, fn, rs, rt, imm, op, b, chk_b, res, br, ill, ovf
      vt[0]  = mk(6'b000000, 6'b100000, 32'd5,        32'd7,        16'h0000, 5'b00001, 32'd7,        1, 32'd12,       0, 0, 0);
      vt[1]  = mk(6'b000000, 6'b100010, 32'd10,       32'd3,        16'h0000, 5'b00010, 32'd3,        1, 32'd7,        0, 0, 0);
      vt[2]  = mk(6'b000000, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 16'h0000, 5'b00100, 32'h0000FF00, 1, 32'h0000F000, 0, 0, 0);
      vt[3]  = mk(6'b000000, 6'b100101, 32'h0000F0F0, 32'h00000F0F, 16'h0000, 5'b10000, 32'h00000F0F, 1, 32'h0000FFFF, 0, 0, 0);
      vt[4]  = mk(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1,        16'h0000, 5'b01000, 32'd1,        1, 32'd1,        0, 0, 0);
      vt[5]  = mk(6'b000100, 6'b000000, 32'h00001234, 32'h00001234, 16'h0000, 5'b00010, 32'h00001234, 1, 32'd0,        1, 0, 0);
      vt[6]  = mk(6'b000101, 6'b000000, 32'h00001234, 32'h00001234, 16'h0000, 5'b00010, 32'h00001234, 1, 32'd0,        0, 0, 0);
      vt[7]  = mk(6'b001100, 6'b000000, 32'h12345678, 32'hDEADBEEF, 16'hFFFF, 5'b00100, 32'h0000FFFF, 1, 32'h00005678, 0, 0, 0);
      vt[8]  = mk(6'b001000, 6'b000000, 32'd5,        32'hDEADBEEF, 16'hFFFF, 5'b00001, 32'hFFFFFFFF, 1, 32'd4,        0, 0, 0);
      vt[9]  = mk(6'b001101, 6'b000000, 32'd1,        32'hDEADBEEF, 16'h8000, 5'b10000, 32'h00008000, 1, 32'h00008001, 0, 0, 0);
      vt[10] = mk(6'b001010, 6'b000000, 32'hFFFFFFFE, 32'hDEADBEEF, 16'hFFFF, 5'b01000, 32'hFFFFFFFF, 1, 32'd1,        0, 0, 0);
      vt[11] = mk(6'b100011, 6'b000000, 32'h00000100, 32'hDEADBEEF, 16'h0010, 5'b00001, 32'h00000010, 1, 32'h00000110, 0, 0, 0);
      vt[12] = mk(6'b101011, 6'b000000, 32'h00010000, 32'hDEADBEEF, 16'h8000, 5'b00001, 32'hFFFF8000, 1, 32'h00008000, 0, 0, 0);
      vt[13] = mk(6'b111111, 6'b000000, 32'd9,        32'd1,        16'h0001, 5'b00000, 32'd0,        0, 32'd0,        0, 1, 0);
      vt[14] = mk(6'b000000, 6'b000000, 32'd9,        32'd1,        16'h0000, 5'b00000, 32'd0,        0, 32'd0,        0, 1, 0);
      vt[15] = mk(6'b000000, 6'b100000, 32'h7FFFFFFF, 32'd1,        16'h0000, 5'b00001, 32'd1,        1, 32'h80000000, 0, 0, 1);
      vt[16] = mk(6'b001000, 6'b000000, 32'h7FFFFFFF, 32'hDEADBEEF, 16'h0001, 5'b00001, 32'd1,        1, 32'h80000000, 0, 0, 1);
      vt[17] = mk(6'b100011, 6'b000000, 32'h7FFFFFFF, 32'hDEADBEEF, 16'h0001, 5'b00001, 32'd1,        1, 32'h80000000, 0, 0, 0);
      vt[18] = mk(6'b000000, 6'b100010, 32'h80000000, 32'd1,        16'h0000, 5'b00010, 32'd1,        1, 32'h7FFFFFFF, 0, 0, 1);
      vt[19] = mk(6'b000100, 6'b000000, 32'h80000000, 32'd1,        16'h0000, 5'b00010, 32'd1,        1, 32'h7FFFFFFF, 0, 0, 0);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm16 = '0; tag_in = '0;

      // Reset state
      #22;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_alu_op",    {27'd0, alu_op},    32'd0);
      check("rst_alu_a",     alu_a,              32'd0);
      check("rst_alu_b",     alu_b,              32'd0);
      check("rst_result",    result,             32'd0);
      check("rst_flags",     {28'd0, br_taken, illegal, overflow, |tag_out}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table: back-to-back issue at full throughput, MEM always ready
      for (int i = 0; i < 20; i++) begin
         issue(vt[i], 5'(i));
         check($sformatf("v%0d_alu_op", i), {27'd0, alu_op}, {27'd0, vt[i].e_op});
         check($sformatf("v%0d_alu_a", i),  alu_a, vt[i].rs);
         if (vt[i].chk_b) check($sformatf("v%0d_alu_b", i), alu_b, vt[i].e_b);
      end
      drain("table_drain");
      check("table_outputs", n_out, 32'd20);

      // Backpressure: A and B fill the pipe, C is refused until MEM releases
      out_ready = 1'b0;
      issue(vt[0], 5'd20);
      issue(vt[1], 5'd21);
      drive(vt[2], 5'd22);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_in_ready",  {31'd0, in_ready},  32'd0);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_tag_hold",  {27'd0, tag_out},   32'd20);
         check("bp_alu_op",    {27'd0, alu_op},    {27'd0, vt[1].e_op});
         check("bp_alu_a",     alu_a,              vt[1].rs);
         check("bp_alu_b",     alu_b,              vt[1].e_b);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      sb_q.push_back(mk_exp(vt[2], 5'd22));
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain("bp_drain");
      check("bp_outputs", n_out, 32'd23);

      // Flush: sub in EX is killed, concurrent instruction refused
      issue(vt[1], 5'd23);
      drive(vt[0], 5'd24);
      flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", {31'd0, in_ready}, 32'd0);
      void'(sb_q.pop_back());
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_bubble_op", {27'd0, alu_op}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("flush_no_output", {31'd0, out_valid}, 32'd0);
      check("flush_outputs",   n_out, 32'd23);

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      issue(vt[0], 5'd25);
      issue(vt[1], 5'd26);
      check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_alu_op",    {27'd0, alu_op},    32'd0);
      check("arst_result",    result,             32'd0);
      sb_q.delete();
      #3 rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

      // Recovery after reset
      issue(vt[7], 5'd27);
      drain("final_drain");
      check("final_outputs", n_out, 32'd24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
